cordic_share_arbiter: RTL

//  Round-robin arbiter that time-shares the single SCICA_CORDIC_wrapper among up to N_REQ clients
//  (ICA norm, ICA rotation, EVD, FFT, k-means). Selects the wrapper stage code (scica_stage_in).

---
 rtl/cordic_share_pkg.sv | 14 +
 rtl/rr_pick.sv | 26 ++
 rtl/cordic_share_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cordic_share_pkg.sv
// Shared types and default parameters for the CORDIC share arbiter.
package cordic_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StGrant,
    StDrain
  } state_e;

  localparam int unsigned DefStageW   = 2;
  localparam logic [7:0]  DefStageMap = 8'hE4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [2:0]       ptr_i,
  output logic             valid_o,
  output logic [2:0]       idx_o
);

  int unsigned cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    cand    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr_i) + i) % N_REQ;
      if (!valid_o && (|(req_i & (N_REQ'(1) << cand)))) begin
        valid_o = 1'b1;
        idx_o   = 3'(cand);
      end
    end
  end

endmodule

// File: rtl/cordic_share_arbiter.sv
// Round-robin time-sharing of the single CORDIC wrapper, with pipe flush on every handover
// and an in-flight counter that holds the grant until all results have returned.
module cordic_share_arbiter
  import cordic_share_pkg::*;
#(
  parameter int unsigned                N_REQ        = 4,
  parameter int unsigned                STAGE_W      = DefStageW,
  parameter logic [N_REQ*STAGE_W-1:0]   STAGE_MAP    = DefStageMap,
  parameter int unsigned                FLUSH_CYCLES = 2,
  parameter int unsigned                OUT_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   rel,
  input  logic               issue,
  input  logic               done,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         grant_idx,
  output logic [STAGE_W-1:0] scica_stage_out,
  output logic               cordic_nrst,
  output logic               busy,
  output logic               err
);

  localparam int unsigned         FlushW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FlushW-1:0]   FlushLast = FlushW'(FLUSH_CYCLES - 1);
  localparam logic [OUT_W-1:0]    OutMax    = '1;
  localparam logic [2:0]          LastIdx   = 3'(N_REQ - 1);

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [2:0]           grant_idx_q, grant_idx_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 nrst_q, nrst_d;
  logic                 err_q, err_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [FlushW-1:0]    flush_cnt_q, flush_cnt_d;

  logic                 pick_valid;
  logic [2:0]           pick_idx;
  logic [N_REQ-1:0]     idx_oh;
  logic                 req_own, rel_own, issue_ok;
  logic [2:0]           next_ptr;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign idx_oh   = N_REQ'(1) << grant_idx_q;
  assign req_own  = |(req & idx_oh);
  assign rel_own  = |(rel & idx_oh);
  assign issue_ok = issue && (state_q == StGrant);
  assign next_ptr = (grant_idx_q == LastIdx) ? 3'd0 : grant_idx_q + 3'd1;

  // Saturating in-flight counter; issues only count while granted, bad events just flag err.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (issue && (state_q != StGrant)) err_d = 1'b1;
    if ((state_q == StDrain) && rel_own) err_d = 1'b1;
    case ({issue_ok, done})
      2'b10: begin
        if (out_q == OutMax) err_d = 1'b1;
        else                 out_d = out_q + 1'b1;
      end
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    stage_d     = stage_q;
    nrst_d      = 1'b1;
    rr_ptr_d    = rr_ptr_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d     = StFlush;
          grant_idx_d = pick_idx;
          stage_d     = STAGE_MAP[pick_idx*STAGE_W +: STAGE_W];
          nrst_d      = 1'b0;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        if (!req_own) begin
          state_d = StIdle;
        end else if (flush_cnt_q == FlushLast) begin
          state_d = StGrant;
          grant_d = idx_oh;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          nrst_d      = 1'b0;
        end
      end
      StGrant: begin
        if (rel_own) begin
          if (out_d == '0) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_d == '0) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= 3'd0;
      stage_q     <= '0;
      nrst_q      <= 1'b0;
      err_q       <= 1'b0;
      out_q       <= '0;
      rr_ptr_q    <= 3'd0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      stage_q     <= stage_d;
      nrst_q      <= nrst_d;
      err_q       <= err_d;
      out_q       <= out_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign grant           = grant_q;
  assign grant_idx       = grant_idx_q;
  assign scica_stage_out = stage_q;
  assign cordic_nrst     = nrst_q;
  assign busy            = (state_q != StIdle);
  assign err             = err_q;

endmodule
